mod_mem_wb_stage: RTL and testbench
===================================

// Module: mod_mem_wb_stage
// PURPOSE
//  MEM/WB pipeline register and writeback logic; sits directly upstream of the register file write port.
//  Captures memory-stage results, then aligns and sign/zero-extends load data.
//  Selects the writeback value from ALU result, load data or PC+4.
//  Drives write_enable/write_addr/write_val for the register file; the same outputs feed decode-stage forwarding.
// PARAMETERS
//  XLEN            `XLEN (32)         datapath width
//  REG_ADDR_WIDTH  `REG_ADDR_WIDTH (5) register index width
//  INSTRET_WIDTH   64                 retired-instruction counter width (only with WB_INSTRET_EN)
// PORTS
//  clk_i           in   1               clock, rising edge
//  rst_i           in   1               asynchronous, active-low reset
//  stall_i         in   1               hold stage contents
//  flush_i         in   1               insert bubble
//  valid_i         in   1               MEM stage holds a real instruction
//  reg_write_i     in   1               instruction writes rd
//  rd_addr_i       in   REG_ADDR_WIDTH  destination register
//  result_src_i    in   2               00 ALU, 01 load, 10 PC+4, 11 reserved
//  load_funct3_i   in   3               LB=000 LH=001 LW=010 LBU=100 LHU=101
//  alu_result_i    in   XLEN            ALU result / load effective address
//  mem_rdata_i     in   XLEN            raw 32-bit word from data memory (word-aligned)
//  pc_plus4_i      in   XLEN            link value for JAL/JALR
//  write_enable_o  out  1               register file write strobe
//  write_addr_o    out  REG_ADDR_WIDTH  register file write index
//  write_val_o     out  XLEN            register file write data
//  load_fault_o    out  1               registered: valid load with illegal funct3 or result_src 11
//  instret_o       out  INSTRET_WIDTH   retired count (only with WB_INSTRET_EN)
// BEHAVIOUR
//  - Reset (rst_i=0, async): all state and outputs 0; instret_o=0.
//  - Latency: 1 cycle; inputs sampled at edge N appear on outputs after edge N.
//  - Edge priority: flush_i > stall_i > capture.
//    - flush_i=1: valid_q<=0 and other fields don't-care, even when stall_i=1.
//    - stall_i=1, flush_i=0: all registers hold; outputs stable.
//    - else: capture valid_i, reg_write_i, rd_addr_i, and the pre-computed write value.
//  - Write value is computed combinationally before the register; only the final XLEN value is stored.
//  - Load alignment uses offset = alu_result_i[1:0].
//    - LB/LBU: byte = mem_rdata_i[8*offset +: 8], sign- or zero-extended.
//    - LH/LHU: half = mem_rdata_i[16*offset[1] +: 16]; offset[0] ignored.
//    - LW: full word; offset ignored.
//  - Illegal load (funct3 011/110/111) or result_src 11: value 0, write suppressed, load_fault_o=1 for that instruction.
//  - write_enable_o = valid_q & reg_write_q & (write_addr_q != 0) & ~fault_q.
//    - rd=x0 never asserts the strobe.
//  - write_addr_o / write_val_o always show the registered values; the consumer qualifies them with write_enable_o.
//  - While stalled, write_enable_o stays high; the register file rewrites the same value harmlessly.
// CONFIGURATION
//  WB_INSTRET_EN defined:
//    - instret_o increments by 1 on each edge where valid_q=1 and the stage advances (stall_i=0, flush_i=0 or 1).
//    - An instruction that leaves the stage under flush still counts; a flush squashes the instruction entering, not the one leaving.
//    - Wraps modulo 2^INSTRET_WIDTH.
//  WB_INSTRET_EN undefined: no counter logic and no instret_o port.
// STRUCTURE
//  - riscv_pkg: result_src_e enum (RES_ALU, RES_LOAD, RES_PC4); load funct3 localparams (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
//  - One sub-module, mod_load_align: purely combinational.
//    - Inputs: mem_rdata, offset, funct3.
//    - Outputs: aligned XLEN value and illegal flag.
// TESTING
//  1. LB, mem_rdata=0x80FF_7F01, offset=3 -> next cycle write_val=0xFFFF_FF80, enable=1.
//     LBU same inputs -> 0x0000_0080.
//  2. LH, offset=2, mem_rdata=0x8001_1234 -> 0xFFFF_8001; LHU -> 0x0000_8001.
//     LH offset=1 -> 0x0000_1234.
//  3. ALU op, rd=0, reg_write=1, alu_result=0x1234 -> write_enable_o=0 after the edge.
//     JAL, rd=1, pc_plus4=0x104 -> write_val=0x104, enable=1.
//  4. Stall for 3 cycles with changing inputs -> outputs frozen at the prior value.
//     Stall+flush together -> write_enable_o=0 after the edge.
//  5. Load with funct3=011 -> load_fault_o=1, write_enable_o=0.
//     Assert rst_i=0 mid-stream between edges -> all outputs 0 immediately.
//  6. (WB_INSTRET_EN) 10 valid instrs, 2 bubbles, 3 stall cycles -> instret_o=10.
//     Preload 2^64-1 and retire one -> instret_o=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V types for the MEM/WB slice: writeback source select
// and load funct3 codes. Default XLEN/REG_ADDR_WIDTH macros live here.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

package riscv_pkg;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10
  } result_src_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/mod_mem_wb_stage_if.sv
// MEM-side inputs and register-file-side outputs of the MEM/WB stage.
// master drives the memory-stage fields; slave is the stage itself.
interface mod_mem_wb_stage_if #(
  parameter int XLEN           = `XLEN,
  parameter int REG_ADDR_WIDTH = `REG_ADDR_WIDTH
);
  logic                      valid_i;
  logic                      reg_write_i;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_i;
  logic [1:0]                result_src_i;
  logic [2:0]                load_funct3_i;
  logic [XLEN-1:0]           alu_result_i;
  logic [XLEN-1:0]           mem_rdata_i;
  logic [XLEN-1:0]           pc_plus4_i;
  logic                      write_enable_o;
  logic [REG_ADDR_WIDTH-1:0] write_addr_o;
  logic [XLEN-1:0]           write_val_o;
  logic                      load_fault_o;

  modport master (
    output valid_i, reg_write_i, rd_addr_i,
    output result_src_i, load_funct3_i,
    output alu_result_i, mem_rdata_i, pc_plus4_i,
    input  write_enable_o, write_addr_o,
    input  write_val_o, load_fault_o
  );

  modport slave (
    input  valid_i, reg_write_i, rd_addr_i,
    input  result_src_i, load_funct3_i,
    input  alu_result_i, mem_rdata_i, pc_plus4_i,
    output write_enable_o, write_addr_o,
    output write_val_o, load_fault_o
  );
endinterface

// File: rtl/mod_mem_wb_stage_load_align.sv
// Combinational load alignment: picks byte/half/word from the raw
// memory word by address offset and sign- or zero-extends it.
module mod_load_align
  import riscv_pkg::*;
#(
  parameter int XLEN = `XLEN
) (
  input  logic [XLEN-1:0] mem_rdata,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] aligned,
  output logic            illegal
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = mem_rdata[{offset, 3'b000} +: 8];
  assign h = mem_rdata[{offset[1], 4'b0000} +: 16];

  always_comb begin
    aligned = '0;
    illegal = 1'b0;
    unique case (1'b1)
      funct3 == F3_LB:  aligned = {{(XLEN-8){b[7]}}, b};
      funct3 == F3_LBU: aligned = {{(XLEN-8){1'b0}}, b};
      funct3 == F3_LH:  aligned = {{(XLEN-16){h[15]}}, h};
      funct3 == F3_LHU: aligned = {{(XLEN-16){1'b0}}, h};
      funct3 == F3_LW:  aligned = mem_rdata;
      default:          illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mod_mem_wb_stage.sv
// MEM/WB pipeline register and writeback select for the register file.
// Optional retired-instruction counter enabled by WB_INSTRET_EN.
module mod_mem_wb_stage
  import riscv_pkg::*;
#(
  parameter int XLEN           = `XLEN,
  parameter int REG_ADDR_WIDTH = `REG_ADDR_WIDTH
`ifdef WB_INSTRET_EN
  ,
  parameter int INSTRET_WIDTH  = 64
`endif
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             flush_i,
  mod_mem_wb_stage_if.slave bus
`ifdef WB_INSTRET_EN
  ,
  output logic [INSTRET_WIDTH-1:0] instret_o
`endif
);

  logic [XLEN-1:0]           ld_val;
  logic                      ld_illegal;
  logic [XLEN-1:0]           wval_d;
  logic                      fault_d;

  logic                      valid_q;
  logic                      rw_q;
  logic [REG_ADDR_WIDTH-1:0] addr_q;
  logic [XLEN-1:0]           val_q;
  logic                      fault_q;

  mod_load_align #(.XLEN(XLEN)) u_align (
    .mem_rdata (bus.mem_rdata_i),
    .offset    (bus.alu_result_i[1:0]),
    .funct3    (bus.load_funct3_i),
    .aligned   (ld_val),
    .illegal   (ld_illegal)
  );

  // A faulting instruction writes zero and never strobes the regfile.
  always_comb begin
    wval_d  = '0;
    fault_d = 1'b0;
    unique case (1'b1)
      bus.result_src_i == RES_ALU:  wval_d = bus.alu_result_i;
      bus.result_src_i == RES_PC4:  wval_d = bus.pc_plus4_i;
      bus.result_src_i == RES_LOAD: begin
        wval_d  = ld_val;
        fault_d = ld_illegal;
      end
      default: fault_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      val_q   <= '0;
      fault_q <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      fault_q <= 1'b0;
    end else if (!stall_i) begin
      valid_q <= bus.valid_i;
      rw_q    <= bus.reg_write_i;
      addr_q  <= bus.rd_addr_i;
      val_q   <= wval_d;
      fault_q <= bus.valid_i & fault_d;
    end
  end

  assign bus.write_enable_o = valid_q & rw_q
                            & (addr_q != '0) & ~fault_q;
  assign bus.write_addr_o   = addr_q;
  assign bus.write_val_o    = val_q;
  assign bus.load_fault_o   = fault_q;

`ifdef WB_INSTRET_EN
  logic [INSTRET_WIDTH-1:0] instret_q;

  // The leaving instruction retires even when a flush kills the entering one.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      instret_q <= '0;
    else if (valid_q && !stall_i)
      instret_q <= instret_q + 1'b1;
  end

  assign instret_o = instret_q;
`endif

endmodule

// File: tb/tb_mod_mem_wb_stage.sv
// Directed self-checking bench for mod_mem_wb_stage.
// Covers load alignment, x0, stall/flush, faults, async reset, instret.
`timescale 1ns/1ps
module tb_mod_mem_wb_stage;
  import riscv_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i;
  logic stall_i;
  logic flush_i;
  int   errors = 0;
  int   checks = 0;

  always #5 clk_i = ~clk_i;

  mod_mem_wb_stage_if #(.XLEN(32), .REG_ADDR_WIDTH(5)) bus ();

`ifdef WB_INSTRET_EN
  logic [63:0] instret_o;
`endif

  mod_mem_wb_stage #(.XLEN(32), .REG_ADDR_WIDTH(5)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .stall_i   (stall_i),
    .flush_i   (flush_i),
    .bus       (bus)
`ifdef WB_INSTRET_EN
    ,
    .instret_o (instret_o)
`endif
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw,
                       input logic [4:0] rd, input logic [1:0] src,
                       input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] rdata, input logic [31:0] pc4);
    bus.valid_i       = v;
    bus.reg_write_i   = rw;
    bus.rd_addr_i     = rd;
    bus.result_src_i  = src;
    bus.load_funct3_i = f3;
    bus.alu_result_i  = alu;
    bus.mem_rdata_i   = rdata;
    bus.pc_plus4_i    = pc4;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i   = 1'b0;
    stall_i = 1'b0;
    flush_i = 1'b0;
    drive(1, 1, 5'd9, 2'b00, 3'd0, 32'h55, 32'h0, 32'h0);
    tick();
    tick();
    chk("rst_we",    bus.write_enable_o, 0);
    chk("rst_addr",  bus.write_addr_o,   0);
    chk("rst_val",   bus.write_val_o,    0);
    chk("rst_fault", bus.load_fault_o,   0);
`ifdef WB_INSTRET_EN
    chk("rst_instret", instret_o, 0);
`endif
    rst_i = 1'b1;

    drive(1, 1, 5'd5, RES_LOAD, F3_LB, 32'h1003, 32'h80FF_7F01, 0);
    tick();
    chk("lb_val",  bus.write_val_o,    32'hFFFF_FF80);
    chk("lb_we",   bus.write_enable_o, 1);
    chk("lb_addr", bus.write_addr_o,   5);

    drive(1, 1, 5'd5, RES_LOAD, F3_LBU, 32'h1003, 32'h80FF_7F01, 0);
    tick();
    chk("lbu_val", bus.write_val_o, 32'h0000_0080);

    drive(1, 1, 5'd6, RES_LOAD, F3_LH, 32'h2002, 32'h8001_1234, 0);
    tick();
    chk("lh2_val", bus.write_val_o, 32'hFFFF_8001);

    drive(1, 1, 5'd6, RES_LOAD, F3_LHU, 32'h2002, 32'h8001_1234, 0);
    tick();
    chk("lhu2_val", bus.write_val_o, 32'h0000_8001);

    drive(1, 1, 5'd6, RES_LOAD, F3_LH, 32'h2001, 32'h8001_1234, 0);
    tick();
    chk("lh1_val", bus.write_val_o, 32'h0000_1234);

    drive(1, 1, 5'd6, RES_LOAD, F3_LW, 32'h2003, 32'h8001_1234, 0);
    tick();
    chk("lw_val", bus.write_val_o, 32'h8001_1234);

    drive(1, 1, 5'd0, RES_ALU, 3'd0, 32'h1234, 32'hFFFF_FFFF, 0);
    tick();
    chk("x0_we",  bus.write_enable_o, 0);
    chk("x0_val", bus.write_val_o,    32'h1234);

    drive(1, 1, 5'd1, RES_PC4, 3'd0, 32'h7777, 32'h0, 32'h104);
    tick();
    chk("jal_val",  bus.write_val_o,    32'h104);
    chk("jal_we",   bus.write_enable_o, 1);
    chk("jal_addr", bus.write_addr_o,   1);

    stall_i = 1'b1;
    drive(1, 1, 5'd9, RES_ALU, 3'd0, 32'hAAAA, 0, 0);
    tick();
    chk("stall1_val", bus.write_val_o, 32'h104);
    drive(0, 0, 5'd10, RES_LOAD, F3_LW, 32'h4, 32'hBBBB, 0);
    tick();
    chk("stall2_val", bus.write_val_o,    32'h104);
    chk("stall2_we",  bus.write_enable_o, 1);
    drive(1, 1, 5'd11, RES_PC4, 3'd0, 0, 0, 32'h200);
    tick();
    chk("stall3_val",  bus.write_val_o,  32'h104);
    chk("stall3_addr", bus.write_addr_o, 1);

    flush_i = 1'b1;
    tick();
    chk("flush_we", bus.write_enable_o, 0);
    flush_i = 1'b0;
    stall_i = 1'b0;

    drive(1, 1, 5'd3, RES_LOAD, 3'b011, 32'h0, 32'h1234_5678, 0);
    tick();
    chk("ill_fault", bus.load_fault_o,   1);
    chk("ill_we",    bus.write_enable_o, 0);
    chk("ill_val",   bus.write_val_o,    0);

    drive(1, 1, 5'd4, 2'b11, 3'd0, 32'h99, 0, 0);
    tick();
    chk("src11_fault", bus.load_fault_o,   1);
    chk("src11_we",    bus.write_enable_o, 0);

    drive(0, 1, 5'd4, RES_ALU, 3'd0, 32'h99, 0, 0);
    tick();
    chk("bubble_we",    bus.write_enable_o, 0);
    chk("bubble_fault", bus.load_fault_o,   0);

    drive(1, 1, 5'd7, RES_ALU, 3'd0, 32'hDEAD_BEEF, 0, 0);
    tick();
    chk("pre_rst_we",  bus.write_enable_o, 1);
    chk("pre_rst_val", bus.write_val_o,    32'hDEAD_BEEF);
    #2;
    rst_i = 1'b0;
    #1;
    chk("async_we",    bus.write_enable_o, 0);
    chk("async_addr",  bus.write_addr_o,   0);
    chk("async_val",   bus.write_val_o,    0);
    chk("async_fault", bus.load_fault_o,   0);
    tick();
    rst_i = 1'b1;

`ifdef WB_INSTRET_EN
    chk("ir_start", instret_o, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 5'd2, RES_ALU, 3'd0, i, 0, 0);
      tick();
    end
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 5'd2, RES_ALU, 3'd0, 32'h50 + i, 0, 0);
      tick();
    end
    chk("ir_stalled", instret_o, 4);
    stall_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 5'd2, RES_ALU, 3'd0, 32'h10 + i, 0, 0);
      tick();
    end
    drive(0, 0, 5'd0, RES_ALU, 3'd0, 0, 0, 0);
    tick();
    tick();
    chk("ir_ten", instret_o, 10);

    drive(1, 1, 5'd2, RES_ALU, 3'd0, 32'h1, 0, 0);
    tick();
    dut.instret_q = '1;
    drive(0, 0, 5'd0, RES_ALU, 3'd0, 0, 0, 0);
    tick();
    chk("ir_wrap", instret_o, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
